// File: rtl/reg_file_init.sv
// -----------------------------------------------------------------------------
// reg_file_init
//
// Integer register file feeding the ALU operands. Two combinational read ports
// (a and b operands), one write port sampled at the rising clock edge. After
// every reset a sequencer clears entries 1..DEPTH-1 to zero, one per cycle,
// then raises ready. Entry 0 is never written and always reads as zero, so it
// needs no clearing.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   When defined, a write in READY is forwarded combinationally to any read
//   port addressing the same non-zero register in the same cycle.
//   When undefined, reads return the stored (pre-edge) value.
//
// Ports:
//   clk    - system clock, rising edge active
//   rst_n  - asynchronous active-low reset
//   ra1    - read address, port 1 (ALU a)
//   ra2    - read address, port 2 (ALU b)
//   rd1    - read data, port 1 (zero during CLEAR or when ra1 == 0)
//   rd2    - read data, port 2 (zero during CLEAR or when ra2 == 0)
//   we     - write enable (ignored during CLEAR)
//   wa     - write address (writes to 0 are discarded)
//   wd     - write data
//   ready  - clear sequence complete, file usable
//   busy   - clear sequence running, always ~ready
//
// Handshake: there is no valid/ready pairing on the write port; a write is
// accepted on any rising edge where ready=1, we=1 and wa!=0, and is lost
// otherwise. Reads are valid whenever ready=1.
// -----------------------------------------------------------------------------
module reg_file_init #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic              ready,
    output logic              busy
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    // State register and clear counter. Counting starts at 1 because entry 0
    // is hardwired to zero on the read side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= FIRST_IDX;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        ready       = 1'b0;
        busy        = 1'b1;
        case (state)
            CLEAR: begin
                if (clr_cnt == LAST_IDX) begin
                    // Hold the counter on the final entry so it never wraps.
                    state_nxt = READY;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            READY: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    // Storage array: no reset; the clear sequence owns the write port while
    // in CLEAR, so external writes in that state are dropped.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    // Combinational read ports.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (state == READY) begin
            if (ra1 != '0) begin
                rd1 = mem[ra1];
`ifdef REGFILE_BYPASS_EN
                // ra1 != 0 already, so a match implies a legal write address.
                if (we && (wa == ra1)) begin
                    rd1 = wd;
                end
`endif
            end
            if (ra2 != '0) begin
                rd2 = mem[ra2];
`ifdef REGFILE_BYPASS_EN
                if (we && (wa == ra2)) begin
                    rd2 = wd;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_reg_file_init.sv
// -----------------------------------------------------------------------------
// tb_reg_file_init
//
// Self-checking bench for reg_file_init at default parameters. A reference
// array holds the architectural register contents; expected read data comes
// from that array plus the x0 and forwarding rules.
// -----------------------------------------------------------------------------
module tb_reg_file_init;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              ready;
    logic              busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    reg_file_init #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ra1  (ra1),
        .ra2  (ra2),
        .rd1  (rd1),
        .rd2  (rd2),
        .we   (we),
        .wa   (wa),
        .wd   (wd),
        .ready(ready),
        .busy (busy)
    );

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    int n_pass;
    int n_total;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] expect_rd(input logic [ADDR_W-1:0] ra,
                                                     input logic t_we,
                                                     input logic [ADDR_W-1:0] t_wa,
                                                     input logic [DATA_W-1:0] t_wd);
        if (ra == 0) return '0;
        if (BYPASS && t_we && (t_wa == ra)) return t_wd;
        return model[ra];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        we    = 1'b0;
        ra1   = 5'd5;
        ra2   = 5'd7;
        #1;
        check_eq("rst_ready", {31'd0, ready}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd1);
        check_eq("rst_rd1", rd1, 32'd0);
        check_eq("rst_rd2", rd2, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs n_edges clock edges after reset release, checking ready/busy
    // timing and that reads stay zero while clearing. Random writes are
    // thrown at the DUT to confirm they are dropped.
    task automatic run_clear(input int n_edges);
        for (int e = 1; e <= n_edges; e++) begin
            we  = 1'($urandom_range(0, 1));
            wa  = ADDR_W'($urandom_range(0, DEPTH - 1));
            wd  = $urandom;
            ra1 = ADDR_W'($urandom_range(0, DEPTH - 1));
            ra2 = ADDR_W'($urandom_range(0, DEPTH - 1));
            if (e == 10) begin
                we = 1'b1;
                wa = 5'd3;
                wd = 32'h0000_1234;
            end
            if (e == DEPTH - 1) we = 1'b0;
            @(posedge clk);
            #1;
            check_eq($sformatf("clr_ready_e%0d", e), {31'd0, ready},
                     (e == DEPTH - 1) ? 32'd1 : 32'd0);
            check_eq($sformatf("clr_busy_e%0d", e), {31'd0, busy},
                     (e == DEPTH - 1) ? 32'd0 : 32'd1);
            if (e < DEPTH - 1) begin
                check_eq("clr_rd1", rd1, 32'd0);
                check_eq("clr_rd2", rd2, 32'd0);
            end
            @(negedge clk);
        end
        we = 1'b0;
    endtask

    // One READY cycle: drive at negedge, check reads before the edge,
    // commit the write into the model at the edge.
    task automatic do_cycle(input logic t_we, input logic [ADDR_W-1:0] t_wa,
                            input logic [DATA_W-1:0] t_wd,
                            input logic [ADDR_W-1:0] t_ra1,
                            input logic [ADDR_W-1:0] t_ra2);
        @(negedge clk);
        we  = t_we;
        wa  = t_wa;
        wd  = t_wd;
        ra1 = t_ra1;
        ra2 = t_ra2;
        #1;
        exp_q.push_back(expect_rd(t_ra1, t_we, t_wa, t_wd));
        exp_q.push_back(expect_rd(t_ra2, t_we, t_wa, t_wd));
        check_eq("rd1", rd1, exp_q.pop_front());
        check_eq("rd2", rd2, exp_q.pop_front());
        check_eq("ready_hold", {31'd0, ready}, 32'd1);
        @(posedge clk);
        if (t_we && (t_wa != 0)) model[t_wa] = t_wd;
    endtask

    task automatic read_all();
        for (int k = 0; k < DEPTH; k++) begin
            do_cycle(1'b0, '0, '0, ADDR_W'(k), ADDR_W'(k));
            check_eq($sformatf("zero_rd1_%0d", k), rd1, 32'd0);
            check_eq($sformatf("zero_rd2_%0d", k), rd2, 32'd0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        we      = 1'b0;
        wa      = '0;
        wd      = '0;
        ra1     = '0;
        ra2     = '0;
        model_clear();

        // Reset, abort the clear at edge 15, reset again and finish it.
        do_reset();
        run_clear(15);
        do_reset();
        run_clear(DEPTH - 1);
        model_clear();
        read_all();

        // Basic write then read on both ports.
        do_cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
        do_cycle(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
        check_eq("basic_rd1", rd1, 32'hDEAD_BEEF);
        check_eq("basic_rd2", rd2, 32'hDEAD_BEEF);

        // x0 protection.
        do_cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd5);
        do_cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        check_eq("x0_rd1", rd1, 32'd0);

        // Same-cycle write and read of register 7.
        do_cycle(1'b1, 5'd7, 32'h1111_1111, 5'd0, 5'd0);
        @(negedge clk);
        we  = 1'b1;
        wa  = 5'd7;
        wd  = 32'hA5A5_A5A5;
        ra1 = 5'd7;
        ra2 = 5'd0;
        #1;
        check_eq("byp_pre", rd1, BYPASS ? 32'hA5A5_A5A5 : 32'h1111_1111);
        check_eq("byp_x0", rd2, 32'd0);
        @(posedge clk);
        model[7] = 32'hA5A5_A5A5;
        #1;
        check_eq("byp_post", rd1, 32'hA5A5_A5A5);
        we = 1'b0;

        // Randomized traffic; narrow address range to force collisions.
        for (int i = 0; i < 300; i++) begin
            logic [ADDR_W-1:0] r_wa;
            logic [ADDR_W-1:0] r_ra1;
            logic [ADDR_W-1:0] r_ra2;
            if ($urandom_range(0, 1) == 0) begin
                r_wa  = ADDR_W'($urandom_range(0, 7));
                r_ra1 = ADDR_W'($urandom_range(0, 7));
                r_ra2 = ADDR_W'($urandom_range(0, 7));
            end else begin
                r_wa  = ADDR_W'($urandom_range(0, DEPTH - 1));
                r_ra1 = ADDR_W'($urandom_range(0, DEPTH - 1));
                r_ra2 = ADDR_W'($urandom_range(0, DEPTH - 1));
            end
            do_cycle(1'($urandom_range(0, 1)), r_wa, $urandom, r_ra1, r_ra2);
        end

        // Reset while READY: old contents must not survive.
        do_reset();
        run_clear(DEPTH - 1);
        model_clear();
        read_all();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_file_init.md
Name: reg_file_init

Overview:
- Integer register file directly upstream of the ALU.
- Two combinational read ports drive the ALU a and b operands. One write port at the rising clock edge receives write-back.
- After reset, a small sequencer clears every register to zero, one entry per cycle, and then raises ready.
- x0 is hardwired to zero.

Parameters:
DATA_W, 32, register and operand width
ADDR_W, 5, register index width
DEPTH, 32, number of registers; must equal 2**ADDR_W

Ports:
clk  input  1  system clock, rising edge active
rst_n  input  1  asynchronous active-low reset
ra1  input  ADDR_W  read address, port 1 (feeds ALU a)
ra2  input  ADDR_W  read address, port 2 (feeds ALU b)
rd1  output  DATA_W  read data, port 1
rd2  output  DATA_W  read data, port 2
we  input  1  write enable
wa  input  ADDR_W  write address
wd  input  DATA_W  write data
ready  output  1  high when the clear sequence is done and the file is usable
busy  output  1  high while the clear sequence runs; always equal to ~ready

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- State machine has two states: CLEAR and READY. The clear counter clr_cnt is ADDR_W bits wide.
- Asynchronous reset, rst_n low:
  - State goes to CLEAR and clr_cnt goes to 1.
  - ready=0, busy=1, rd1=rd2=0.
  - The array is not reset directly.
- CLEAR state:
  - Each rising edge writes 0 to entry clr_cnt, then increments clr_cnt.
  - The edge that clears entry DEPTH-1 moves the state to READY.
  - ready rises after edge DEPTH-1 following rst_n release: edge 31 at the defaults.
- READY state: terminal until the next reset.
- Writes during CLEAR: external we is ignored and the write is lost. No queueing.
- Reads during CLEAR: rd1 and rd2 are forced to 0.
- Reads in READY: combinational, zero latency. rdN = 0 if raN == 0, otherwise mem[raN].
- Writes in READY:
  - If we=1 and wa!=0, mem[wa] takes wd at the rising edge.
  - If wa==0, the write is silently discarded.
- Same address on ra1 and ra2: both ports return the same value.
- Reset mid-clear: the sequence restarts from entry 1. Entries already cleared stay zero and are cleared again.
- Reset in READY: contents are re-cleared over the next DEPTH-1 cycles. Prior values are never visible after reset.
- No arithmetic on data. clr_cnt must not wrap to 0 during CLEAR, because the transition to READY happens at DEPTH-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - In READY, if we=1 and wa!=0 and wa==raN, rdN = wd in the same cycle (write-through forwarding).
  - The x0 rule still wins: raN==0 always returns 0.
  - Bypass is inactive during CLEAR.
- Undefined:
  - rdN returns the pre-edge value mem[raN].
  - The new value is visible only after the rising edge.

Test Plan:
- Clear latency:
  - Stimulus: pulse rst_n low, release, count edges.
  - Required: ready=0 through edge 30; ready=1 after edge 31; busy is the complement throughout.
  - Required: after ready, ra1=ra2=k returns 0 for all k.
- Basic write/read:
  - Stimulus: in READY, write wa=5, wd=0xDEADBEEF; next cycle read ra1=5, ra2=5.
  - Required: rd1=rd2=0xDEADBEEF.
- x0 protection:
  - Stimulus: write wa=0, wd=0xFFFFFFFF; read ra1=0.
  - Required: rd1=0.
- Write during CLEAR:
  - Stimulus: assert we with wa=3, wd=0x1234 at edge 10 after reset.
  - Required: after ready, reading ra2=3 returns 0.
- Reset mid-clear:
  - Stimulus: assert rst_n low at edge 15, release.
  - Required: ready asserts exactly 31 edges after the second release; all entries read 0.
- Bypass:
  - Stimulus: in READY, write wa=7, wd=0xA5A5A5A5 with ra1=7 in the same cycle.
  - Required with REGFILE_BYPASS_EN: rd1=0xA5A5A5A5 before the edge.
  - Required without the macro: rd1 shows the old value before the edge and 0xA5A5A5A5 after it.
